// File: rtl/cpmg_if.sv
// cpmg_if: configuration, control and DAC-side signals of the CPMG sequencer
interface cpmg_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 32,
  parameter int ECHO_W = 16
);
  logic [CNT_W-1:0]  cfg_tau;
  logic [CNT_W-1:0]  cfg_tau_l;
  logic [ECHO_W-1:0] cfg_n_echo;
  logic [DATA_W-1:0] cfg_amp;
  logic              cfg_phase_alt;
  logic              start;
  logic              sync_pulse;
  logic              abort;
  logic [DATA_W-1:0] data;
  logic              busy;
  logic              done;
  logic              cfg_err;
  logic              acq_gate;
  logic [ECHO_W-1:0] echo_idx;
  modport master (
    output cfg_tau, cfg_tau_l, cfg_n_echo, cfg_amp, cfg_phase_alt, start, sync_pulse, abort,
    input  data, busy, done, cfg_err, acq_gate, echo_idx
  );
  modport slave (
    input  cfg_tau, cfg_tau_l, cfg_n_echo, cfg_amp, cfg_phase_alt, start, sync_pulse, abort,
    output data, busy, done, cfg_err, acq_gate, echo_idx
  );
endinterface

// File: rtl/cpmg_seq.sv
// cpmg_seq: CPMG pulse sequencer producing 90/180-degree pulses and echo acquisition gates
module cpmg_seq #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 32,
  parameter int ECHO_W = 16
) (
  input logic   clk,
  input logic   rst,
  cpmg_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ARM, P90, D1, P180, D2, DONE} state_t;
  state_t            state_q;
  logic [CNT_W:0]    cnt_q;
  logic [CNT_W-1:0]  tau_q, tau_l_q;
  logic [ECHO_W-1:0] n_echo_q, idx_q;
  logic [DATA_W-1:0] amp_q, data_q;
  logic              alt_q, busy_q, done_q, cfg_err_q, acq_q;
  logic [CNT_W:0]    tau_m1, tau_l_m1, tau2_m1, tau_l2_m1;
  logic [ECHO_W:0]   idx_inc;
  logic [DATA_W-1:0] amp_neg;
  // Segment lengths minus one, since the counter runs down to zero inclusive
  assign tau_m1    = {1'b0, tau_q} - (CNT_W+1)'(1);
  assign tau_l_m1  = {1'b0, tau_l_q} - (CNT_W+1)'(1);
  assign tau2_m1   = {tau_q, 1'b0} - (CNT_W+1)'(1);
  assign tau_l2_m1 = {tau_l_q, 1'b0} - (CNT_W+1)'(1);
  assign idx_inc   = {1'b0, idx_q} + (ECHO_W+1)'(1);
  assign amp_neg   = -amp_q;
  assign bus.data     = data_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.cfg_err  = cfg_err_q;
  assign bus.acq_gate = acq_q;
  assign bus.echo_idx = idx_q;
  // Sequencer FSM; outputs are registered alongside the state they belong to
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tau_q     <= '0;
      tau_l_q   <= '0;
      n_echo_q  <= '0;
      amp_q     <= '0;
      alt_q     <= 1'b0;
      idx_q     <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      acq_q     <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      if (bus.abort && state_q != IDLE) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        idx_q   <= '0;
        data_q  <= '0;
        busy_q  <= 1'b0;
        acq_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            idx_q <= '0;
            if (bus.start && bus.cfg_tau != '0 && bus.cfg_tau_l != '0) begin
              tau_q    <= bus.cfg_tau;
              tau_l_q  <= bus.cfg_tau_l;
              n_echo_q <= bus.cfg_n_echo;
              amp_q    <= bus.cfg_amp;
              alt_q    <= bus.cfg_phase_alt;
              busy_q   <= 1'b1;
              state_q  <= ARM;
            end else if (bus.start) begin
              cfg_err_q <= 1'b1;
            end
          end
          ARM: if (bus.sync_pulse) begin
            state_q <= P90;
            data_q  <= amp_q;
            cnt_q   <= tau_m1;
          end
          P90: if (cnt_q == '0) begin
            state_q <= D1;
            data_q  <= '0;
            cnt_q   <= tau_l_m1;
          end else cnt_q <= cnt_q - 1'b1;
          D1: if (cnt_q == '0) begin
            state_q <= n_echo_q == '0 ? DONE : P180;
            done_q  <= n_echo_q == '0;
            data_q  <= n_echo_q == '0 ? '0 : amp_q;
            cnt_q   <= tau2_m1;
          end else cnt_q <= cnt_q - 1'b1;
          P180: if (cnt_q == '0) begin
            state_q <= D2;
            data_q  <= '0;
            acq_q   <= 1'b1;
            cnt_q   <= tau_l2_m1;
          end else cnt_q <= cnt_q - 1'b1;
          D2: if (cnt_q == '0) begin
            idx_q   <= idx_inc[ECHO_W-1:0];
            acq_q   <= 1'b0;
            cnt_q   <= tau2_m1;
            state_q <= idx_inc < {1'b0, n_echo_q} ? P180 : DONE;
            done_q  <= !(idx_inc < {1'b0, n_echo_q});
            data_q  <= !(idx_inc < {1'b0, n_echo_q}) ? '0 : (alt_q && idx_inc[0]) ? amp_neg : amp_q;
          end else cnt_q <= cnt_q - 1'b1;
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            idx_q   <= '0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule
